// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates mouse/CPU moves onto the one-hot cuadro bus with hold and gap timing
// Ports:
//   clk_100MHz, reset (async, active-low)
//   vs_cpu, turnoX, accept, x_occ, o_occ : game context from the board FSM
//   mouse_req/mouse_cell, cpu_req/cpu_cell : level requests with a 4-bit cell
//   cuadro : one-hot accepted move, mouse_ack/nak, cpu_ack/nak : result pulses
//   busy : high whenever the scheduler is not idle
module move_scheduler #(
  parameter int HOLD_CYCLES = 32,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       vs_cpu,
  input  logic       turnoX,
  input  logic       accept,
  input  logic [8:0] x_occ,
  input  logic [8:0] o_occ,
  input  logic       mouse_req,
  input  logic [3:0] mouse_cell,
  input  logic       cpu_req,
  input  logic [3:0] cpu_cell,
  output logic [8:0] cuadro,
  output logic       mouse_ack,
  output logic       mouse_nak,
  output logic       cpu_ack,
  output logic       cpu_nak,
  output logic       busy
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HLOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GLOAD = CW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD, GAP, NAKW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0] cuadro_n, hot;
  logic [3:0] e_cell;
  logic m_elig, valid, m_ack_n, m_nak_n, c_ack_n, c_nak_n;
  // mouse owns the move unless playing the CPU on O's turn
  assign m_elig = !vs_cpu || turnoX;
  assign e_cell = m_elig ? mouse_cell : cpu_cell;
  // cells 9..15 shift out of the 9-bit vector and yield zero
  assign hot = 9'd1 << e_cell;
  assign valid = |hot && ~|(hot & (x_occ | o_occ));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cuadro_n = cuadro;
    m_ack_n = 1'b0;
    m_nak_n = 1'b0;
    c_ack_n = 1'b0;
    c_nak_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        m_ack_n = m_elig && mouse_req && valid;
        m_nak_n = mouse_req && !(m_elig && valid);
        c_ack_n = !m_elig && cpu_req && valid;
        c_nak_n = cpu_req && !(!m_elig && valid);
        state_n = (m_ack_n || c_ack_n) ? HOLD : (m_nak_n || c_nak_n) ? NAKW : IDLE;
        cuadro_n = (m_ack_n || c_ack_n) ? hot : '0;
        cnt_n = HLOAD;
      end
      HOLD: begin
        state_n = cnt == '0 ? GAP : HOLD;
        cuadro_n = cnt == '0 ? '0 : cuadro;
        cnt_n = cnt == '0 ? GLOAD : cnt - CW'(1);
      end
      GAP: begin
        state_n = cnt == '0 ? IDLE : GAP;
        cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
      end
      NAKW: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      cuadro <= '0;
      mouse_ack <= 1'b0;
      mouse_nak <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_nak <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cuadro <= cuadro_n;
      mouse_ack <= m_ack_n;
      mouse_nak <= m_nak_n;
      cpu_ack <= c_ack_n;
      cpu_nak <= c_nak_n;
      busy <= state_n != IDLE;
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: scoreboard bench for move_scheduler
module tb_move_scheduler;
  logic clk_100MHz = 1'b0;
  logic reset = 1'b0;
  logic vs_cpu = 1'b0, turnoX = 1'b1, accept = 1'b1;
  logic [8:0] x_occ = '0, o_occ = '0;
  logic mouse_req = 1'b0, cpu_req = 1'b0;
  logic [3:0] mouse_cell = '0, cpu_cell = '0;
  logic [8:0] cuadro;
  logic mouse_ack, mouse_nak, cpu_ack, cpu_nak, busy;
  int errors = 0, checks = 0;
  logic [12:0] sb[$];
  move_scheduler dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .vs_cpu(vs_cpu), .turnoX(turnoX),
    .accept(accept), .x_occ(x_occ), .o_occ(o_occ), .mouse_req(mouse_req),
    .mouse_cell(mouse_cell), .cpu_req(cpu_req), .cpu_cell(cpu_cell),
    .cuadro(cuadro), .mouse_ack(mouse_ack), .mouse_nak(mouse_nak),
    .cpu_ack(cpu_ack), .cpu_nak(cpu_nak), .busy(busy)
  );
  always #5 clk_100MHz = ~clk_100MHz;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // every result pulse must match the oldest outstanding expectation
  always @(negedge clk_100MHz) begin
    logic [12:0] e;
    if ({mouse_ack, mouse_nak, cpu_ack, cpu_nak} != 4'b0) begin
      if (sb.size() == 0) check("unexpected_pulse", {19'b0, mouse_ack, mouse_nak, cpu_ack, cpu_nak, cuadro}, 32'h0);
      else begin
        e = sb.pop_front();
        check("resp", {19'b0, mouse_ack, mouse_nak, cpu_ack, cpu_nak, cuadro}, {19'b0, e});
      end
    end
  end
  // drive one request so it is sampled on the next rising edge, then drop it
  task automatic req(input logic m, input logic [3:0] mc, input logic c, input logic [3:0] cc, input logic [12:0] exp);
    sb.push_back(exp);
    mouse_req = m;
    mouse_cell = mc;
    cpu_req = c;
    cpu_cell = cc;
    @(posedge clk_100MHz);
    #2;
    mouse_req = 1'b0;
    cpu_req = 1'b0;
  endtask
  task automatic watch_move(input logic [8:0] exp, input bit perturb);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_100MHz);
      if (cuadro === exp && busy === 1'b1) n++;
      if (perturb && i == 5) turnoX = ~turnoX;
      if (perturb && i == 10) accept = 1'b0;
      if (perturb && i == 15) x_occ = 9'h1FF;
      if (perturb && i == 20) begin
        turnoX = ~turnoX;
        accept = 1'b1;
        x_occ = '0;
      end
    end
    check("hold_cycles", n, 32);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_100MHz);
      if (cuadro === 9'h0 && busy === 1'b1) n++;
    end
    check("gap_cycles", n, 16);
    @(negedge clk_100MHz);
    check("idle_busy", busy, 0);
    check("drain", sb.size(), 0);
  endtask
  task automatic nak_once(input logic m, input logic [3:0] mc, input logic c, input logic [3:0] cc, input logic [12:0] exp);
    req(m, mc, c, cc, exp);
    @(negedge clk_100MHz);
    check("nak_cuadro", cuadro, 0);
    check("nak_busy", busy, 1);
    @(negedge clk_100MHz);
    check("nakw_exit_busy", busy, 0);
    check("drain", sb.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    repeat (3) @(negedge clk_100MHz);
    check("rst_cuadro", cuadro, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {mouse_ack, mouse_nak, cpu_ack, cpu_nak}, 0);
    @(posedge clk_100MHz);
    #2 reset = 1'b1;
    @(posedge clk_100MHz);
    #2;
    // basic mouse move
    req(1, 4'd4, 0, 4'd0, {4'b1000, 9'h010});
    watch_move(9'h010, 0);
    // occupied cell
    x_occ = 9'h001;
    nak_once(1, 4'd0, 0, 4'd0, {4'b0100, 9'h0});
    x_occ = '0;
    // out-of-range held request is nak'd again two cycles later
    sb.push_back({4'b0100, 9'h0});
    sb.push_back({4'b0100, 9'h0});
    mouse_req = 1'b1;
    mouse_cell = 4'd12;
    @(negedge clk_100MHz);
    check("oor_nak0", mouse_nak, 1);
    @(negedge clk_100MHz);
    check("oor_nak1", mouse_nak, 0);
    @(negedge clk_100MHz);
    check("oor_nak2", mouse_nak, 1);
    check("oor_cuadro", cuadro, 0);
    mouse_req = 1'b0;
    @(negedge clk_100MHz);
    check("drain", sb.size(), 0);
    // boundaries: cell 9 rejected, cell 8 occupied by O, then cell 8 free
    nak_once(1, 4'd9, 0, 4'd0, {4'b0100, 9'h0});
    o_occ = 9'h100;
    nak_once(1, 4'd8, 0, 4'd0, {4'b0100, 9'h0});
    o_occ = '0;
    req(1, 4'd8, 0, 4'd0, {4'b1000, 9'h100});
    watch_move(9'h100, 0);
    // CPU request in two-human mode is never eligible
    nak_once(0, 4'd0, 1, 4'd3, {4'b0001, 9'h0});
    // turn enforcement with CPU
    vs_cpu = 1'b1;
    turnoX = 1'b0;
    req(1, 4'd2, 1, 4'd6, {4'b0110, 9'h040});
    watch_move(9'h040, 0);
    x_occ = 9'h008;
    nak_once(0, 4'd0, 1, 4'd3, {4'b0001, 9'h0});
    x_occ = '0;
    turnoX = 1'b1;
    req(1, 4'd0, 1, 4'd1, {4'b1001, 9'h001});
    watch_move(9'h001, 0);
    vs_cpu = 1'b0;
    // accept gating
    accept = 1'b0;
    mouse_req = 1'b1;
    mouse_cell = 4'd3;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_100MHz);
      if ({mouse_ack, mouse_nak, cpu_ack, cpu_nak} != 4'b0 || busy) n++;
    end
    check("gate_quiet", n, 0);
    sb.push_back({4'b1000, 9'h008});
    @(posedge clk_100MHz);
    #2 accept = 1'b1;
    @(posedge clk_100MHz);
    #2 mouse_req = 1'b0;
    watch_move(9'h008, 0);
    // stability while inputs change during the hold
    req(1, 4'd5, 0, 4'd0, {4'b1000, 9'h020});
    watch_move(9'h020, 1);
    // reset mid-hold
    req(1, 4'd7, 0, 4'd0, {4'b1000, 9'h080});
    repeat (10) @(negedge clk_100MHz);
    check("midhold_cuadro", cuadro, 9'h080);
    #1 reset = 1'b0;
    #1;
    check("arst_cuadro", cuadro, 0);
    check("arst_busy", busy, 0);
    @(posedge clk_100MHz);
    #2 reset = 1'b1;
    req(1, 4'd1, 0, 4'd0, {4'b1000, 9'h002});
    watch_move(9'h002, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
